// File: rtl/pll_phase_shifter.sv
// Drives the ALTPLL-style dynamic phase-shift port of one of two PLLs.
// Each requested period becomes one phasestep pulse, handshaked on phasedone.
module pll_phase_shifter #(
   parameter int CNT_W            = 8,
   parameter int PHASESTEP_CYCLES = 2,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_shift_ready,
   input  logic [CNT_W-1:0] i_periods_to_process,
   input  logic [2:0]       i_phasecounterselect_1,
   input  logic [2:0]       i_phasecounterselect_2,
   input  logic             i_pll_to_update,
   input  logic             i_phaseupdown,
   input  logic             i_phasedone_1,
   input  logic             i_phasedone_2,
   output logic [2:0]       o_phasecounterselect_1,
   output logic [2:0]       o_phasecounterselect_2,
   output logic             o_phaseupdown,
   output logic             o_phasestep_1,
   output logic             o_phasestep_2,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [CNT_W-1:0] o_steps_remaining
);

   localparam int STP_W = $clog2(PHASESTEP_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STEP, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
   } state_t;

   state_t             state_q;
   logic               pd1_meta_q, pd1_sync_q, pd2_meta_q, pd2_sync_q;
   logic               shift_prev_q;
   logic               pll_q;
   logic [2:0]         sel1_q, sel2_q;
   logic               updown_q;
   logic               ps1_q, ps2_q;
   logic               busy_q, done_q, error_q;
   logic [CNT_W-1:0]   steps_q;
   logic [STP_W-1:0]   step_cnt_q;
   logic [TMO_W-1:0]   tmo_q;

   logic cmd_d;
   logic pd_sel_d;

   assign cmd_d    = i_shift_ready & ~shift_prev_q;
   assign pd_sel_d = pll_q ? pd2_sync_q : pd1_sync_q;

   // phasedone arrives from the PLL clock domain, so it is double-registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pd1_meta_q   <= 1'b0;
         pd1_sync_q   <= 1'b0;
         pd2_meta_q   <= 1'b0;
         pd2_sync_q   <= 1'b0;
         shift_prev_q <= 1'b0;
      end else begin
         pd1_meta_q   <= i_phasedone_1;
         pd1_sync_q   <= pd1_meta_q;
         pd2_meta_q   <= i_phasedone_2;
         pd2_sync_q   <= pd2_meta_q;
         shift_prev_q <= i_shift_ready;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         pll_q      <= 1'b0;
         sel1_q     <= 3'b110;
         sel2_q     <= 3'b110;
         updown_q   <= 1'b1;
         ps1_q      <= 1'b0;
         ps2_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         steps_q    <= '0;
         step_cnt_q <= '0;
         tmo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_d && (i_periods_to_process != '0)) begin
                  pll_q    <= i_pll_to_update;
                  updown_q <= i_phaseupdown;
                  if (i_pll_to_update) sel2_q <= i_phasecounterselect_2;
                  else                 sel1_q <= i_phasecounterselect_1;
                  steps_q  <= i_periods_to_process;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SETUP;
               end
            end
            S_SETUP: begin
               step_cnt_q <= '0;
               if (pll_q) ps2_q <= 1'b1;
               else       ps1_q <= 1'b1;
               state_q <= S_STEP;
            end
            S_STEP: begin
               if (step_cnt_q == STP_W'(PHASESTEP_CYCLES - 1)) begin
                  ps1_q   <= 1'b0;
                  ps2_q   <= 1'b0;
                  tmo_q   <= '0;
                  state_q <= S_WAIT_LOW;
               end else begin
                  step_cnt_q <= step_cnt_q + STP_W'(1);
               end
            end
            S_WAIT_LOW: begin
               if (!pd_sel_d) begin
                  tmo_q   <= '0;
                  state_q <= S_WAIT_HIGH;
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            S_WAIT_HIGH: begin
               if (pd_sel_d) begin
                  if (steps_q != '0) steps_q <= steps_q - CNT_W'(1);
                  // Finishing on the last step (or an already-empty count) ends the job
                  if (steps_q <= CNT_W'(1)) state_q <= S_DONE;
                  else                      state_q <= S_SETUP;
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               ps1_q   <= 1'b0;
               ps2_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_phasecounterselect_1 = sel1_q;
   assign o_phasecounterselect_2 = sel2_q;
   assign o_phaseupdown          = updown_q;
   assign o_phasestep_1          = ps1_q;
   assign o_phasestep_2          = ps2_q;
   assign o_busy                 = busy_q;
   assign o_done                 = done_q;
   assign o_error                = error_q;
   assign o_steps_remaining      = steps_q;

endmodule
